// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect,
// and the instruction handed to decode.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_out, pc_out,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_out, pc_out,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, keeps up to DEPTH instructions in flight,
// queues returned words in order and squashes wrong-path work on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master ifu_if
);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {FETCH, FLUSH} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d, last_pc_q;
  logic          req_q, req_d;
  logic [CW-1:0] out_q, out_d, cnt_q, cnt_d, drop_q, drop_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, fl_rd_q, fl_wr_q;
  entry_t        q_mem [DEPTH];
  logic [31:0]   fl_pc [DEPTH];
  entry_t        head;
  logic          acc, rsp, redir, pop, push, head_vld;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign acc      = req_q & ifu_if.imem_ready;
  assign rsp      = ifu_if.imem_rvalid;
  assign redir    = ifu_if.redirect_valid;
  assign head_vld = (cnt_q != '0);
  // A redirect squashes the head, so decode never consumes it that cycle.
  assign pop      = head_vld & ifu_if.inst_ready & ~redir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redir)
      state_d = (drop_d != '0) ? FLUSH : FETCH;
    else if (state_q == FLUSH && rsp && drop_q == CW'(1))
      state_d = FETCH;
  end

  always_comb begin
    push               = (state_q == FETCH) & rsp & ~redir;
    head               = q_mem[rd_q];
    ifu_if.imem_req    = req_q;
    ifu_if.imem_addr   = fetch_pc_q;
    ifu_if.inst_valid  = head_vld;
    ifu_if.inst_out    = head_vld ? head.inst : NOP;
    ifu_if.pc_out      = head_vld ? head.pc   : last_pc_q;
  end

  always_comb begin
    out_d      = out_q + CW'(acc) - CW'(rsp);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    fetch_pc_d = acc ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rd_d       = pop  ? inc(rd_q) : rd_q;
    wr_d       = push ? inc(wr_q) : wr_q;
    drop_d     = drop_q;
    if (state_q == FLUSH && rsp) drop_d = drop_q - CW'(1);
    // Everything still outstanding after this edge, including a request accepted
    // right now, belongs to the wrong path.
    if (redir) begin
      fetch_pc_d = ifu_if.redirect_pc & ~32'd3;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
      drop_d     = out_d;
    end
    req_d = ({1'b0, out_d} + {1'b0, cnt_d}) < DEPTH_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      out_q      <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      fl_rd_q    <= '0;
      fl_wr_q    <= '0;
      last_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      if (acc)      fl_wr_q   <= inc(fl_wr_q);
      if (rsp)      fl_rd_q   <= inc(fl_rd_q);
      if (head_vld) last_pc_q <= head.pc;
    end
  end

  // In-flight PCs stay in lockstep with memory order even for dropped responses.
  always_ff @(posedge clk) begin
    if (acc)  fl_pc[fl_wr_q] <= fetch_pc_q;
    if (push) q_mem[wr_q]    <= '{pc: fl_pc[fl_rd_q], inst: ifu_if.imem_rdata};
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle tables for start-up and backpressure,
// hand sequences for redirects, ready toggling, PC wrap and mid-stream reset.
module tb_instr_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ifu_if (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int mem_lat = 1;   // response sampled lat+1 edges after the accepting edge
  int mem_mode = 0;  // 0: always ready, 1: ready every other cycle, 2: never ready
  int mcyc = 0;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t pend[$];

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[$];

  logic        held;
  logic [31:0] haddr, exp_pc;
  int          ndel;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  // Memory model: decides ready/rvalid on the falling edge for the next rising edge.
  always @(negedge clk) begin
    mcyc++;
    if (!rst_n) begin
      pend.delete();
      bus.imem_ready  = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end else begin
      case (mem_mode)
        0:       bus.imem_ready = 1'b1;
        1:       bus.imem_ready = mcyc[0];
        default: bus.imem_ready = 1'b0;
      endcase
      if (bus.imem_req && bus.imem_ready)
        pend.push_back('{mcyc + 1 + mem_lat, bus.imem_addr});
      if (pend.size() > 0 && pend[0].due <= mcyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},  32'(bus.imem_req),   32'd0);
    chk({tag, "_addr"}, bus.imem_addr,       32'h0);
    chk({tag, "_vld"},  32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"}, bus.inst_out,        NOP);
    chk({tag, "_pc"},   bus.pc_out,          32'h0);
  endtask

  task automatic do_reset();
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    rst_n = 1'b0;
    #1;
    chk_reset("reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic collect(input string name, input int n, input int budget, input logic [31:0] first);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (bus.inst_valid) begin
        chk({name, "_pc"},   bus.pc_out,   first + 32'(4 * got));
        chk({name, "_inst"}, bus.inst_out, word_of(first + 32'(4 * got)));
        got++;
      end
      tick();
    end
    chk({name, "_delivered"}, 32'(got), 32'(n));
  endtask

  initial begin
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Start-up with decode always ready: 1-cycle memory, first instruction two edges after first accept.
    tbl.push_back('{1, 1, 0, 32'h00, 0, 32'h00});
    tbl.push_back('{0, 1, 1, 32'h00, 0, 32'h00});
    tbl.push_back('{0, 1, 1, 32'h04, 0, 32'h00});
    tbl.push_back('{0, 1, 1, 32'h08, 0, 32'h00});
    tbl.push_back('{0, 1, 1, 32'h0C, 1, 32'h00});
    tbl.push_back('{0, 1, 1, 32'h10, 1, 32'h04});
    tbl.push_back('{0, 1, 1, 32'h14, 1, 32'h08});
    tbl.push_back('{0, 1, 1, 32'h18, 1, 32'h0C});
    // Decode stalled: four requests fill the window, then drain resumes fetch at 0x10.
    tbl.push_back('{1, 0, 0, 32'h00, 0, 32'h00});
    tbl.push_back('{0, 0, 1, 32'h00, 0, 32'h00});
    tbl.push_back('{0, 0, 1, 32'h04, 0, 32'h00});
    tbl.push_back('{0, 0, 1, 32'h08, 0, 32'h00});
    tbl.push_back('{0, 0, 1, 32'h0C, 1, 32'h00});
    tbl.push_back('{0, 0, 0, 32'h10, 1, 32'h00});
    tbl.push_back('{0, 0, 0, 32'h10, 1, 32'h00});
    tbl.push_back('{0, 0, 0, 32'h10, 1, 32'h00});
    tbl.push_back('{0, 1, 0, 32'h10, 1, 32'h00});
    tbl.push_back('{0, 1, 1, 32'h10, 1, 32'h04});
    tbl.push_back('{0, 1, 1, 32'h14, 1, 32'h08});
    tbl.push_back('{0, 1, 1, 32'h18, 1, 32'h0C});
    tbl.push_back('{0, 1, 1, 32'h1C, 1, 32'h10});
    tbl.push_back('{0, 1, 1, 32'h20, 1, 32'h14});

    mem_lat  = 1;
    mem_mode = 0;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      chk($sformatf("v%0d_req", i),  32'(bus.imem_req),   32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i), bus.imem_addr,       tbl[i].addr);
      chk($sformatf("v%0d_vld", i),  32'(bus.inst_valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d_inst", i), bus.inst_out,        tbl[i].vld ? word_of(tbl[i].pc) : NOP);
      chk($sformatf("v%0d_pc", i),   bus.pc_out,          tbl[i].pc);
      bus.inst_ready = tbl[i].rdy;
      tick();
    end

    // Redirect to 0x100 while three 3-cycle requests are outstanding.
    mem_lat  = 3;
    mem_mode = 0;
    do_reset();
    bus.inst_ready = 1'b1;
    tick(); tick(); tick();
    mem_mode = 2;
    tick();
    chk("c_addr_pre", bus.imem_addr, 32'h0C);
    chk("c_noacc_pre", 32'(bus.imem_ready), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    mem_mode = 0;
    tick();
    bus.redirect_valid = 1'b0;
    chk("c_vld_post", 32'(bus.inst_valid), 32'd0);
    chk("c_addr_post", bus.imem_addr, 32'h100);
    collect("c", 4, 40, 32'h100);

    // Redirect to 0x203 in the same cycle as an accept and a response.
    mem_lat  = 1;
    mem_mode = 0;
    do_reset();
    bus.inst_ready = 1'b1;
    repeat (5) tick();
    chk("d_coincide", 32'(bus.imem_req && bus.imem_ready && bus.imem_rvalid), 32'd1);
    chk("d_pc_pre", bus.pc_out, 32'h04);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0203;
    tick();
    bus.redirect_valid = 1'b0;
    chk("d_addr_post", bus.imem_addr, 32'h200);
    chk("d_vld_post", 32'(bus.inst_valid), 32'd0);
    chk("d_inst_post", bus.inst_out, NOP);
    collect("d", 3, 30, 32'h200);

    // Memory ready toggling: address holds while unaccepted, PCs arrive gap-free.
    mem_mode = 1;
    do_reset();
    bus.inst_ready = 1'b1;
    held   = 1'b0;
    haddr  = 32'h0;
    exp_pc = 32'h0;
    ndel   = 0;
    for (int c = 0; c < 40; c++) begin
      if (held) chk("e_addr_hold", bus.imem_addr, haddr);
      held  = bus.imem_req && !bus.imem_ready;
      haddr = bus.imem_addr;
      if (bus.inst_valid) begin
        chk("e_pc", bus.pc_out, exp_pc);
        chk("e_inst", bus.inst_out, word_of(exp_pc));
        exp_pc += 32'd4;
        ndel++;
      end
      tick();
    end
    chk("e_enough", 32'(ndel >= 10), 32'd1);

    // PC wrap past 0xFFFF_FFFC, then asynchronous reset mid-stream.
    mem_mode = 0;
    do_reset();
    bus.inst_ready = 1'b1;
    repeat (5) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    chk("f_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("f_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("f_addr2", bus.imem_addr, 32'h0000_0000);
    collect("f", 4, 20, 32'hFFFF_FFF8);
    chk("f_vld_pre_rst", 32'(bus.inst_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("f_async");
    tick();
    rst_n = 1'b1;
    tick();
    chk("f_req_after", 32'(bus.imem_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
